// File: rtl/if_id_stage_pkg.sv
// Shared MIPS decode constants for the IF/ID stage: opcodes, field positions
// and the immediate-extension select encoding.
package if_id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;

  localparam logic EXT_SIGN = 1'b1;
  localparam logic EXT_ZERO = 1'b0;

  // The logical-immediate group (andi/ori/xori/lui) shares opcode[5:2]; only it zero-extends.
  function automatic logic ext_op(input logic [5:0] opcode);
    return (opcode[5:2] == OP_ANDI[5:2]) ? EXT_ZERO : EXT_SIGN;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch/decode-facing bus of the IF/ID stage. The stage uses the slave modport.
// IF_ID_STALL_CNT_EN adds the stall_cnt observation signal.
interface if_id_stage_if;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic        out_extop;
  logic [25:0] out_jidx;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  modport master (
`ifdef IF_ID_STALL_CNT_EN
    input  stall_cnt,
`endif
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_plus4, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_extop, out_jidx
  );

  modport slave (
`ifdef IF_ID_STALL_CNT_EN
    output stall_cnt,
`endif
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_pc_plus4, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_extop, out_jidx
  );

endinterface

// File: rtl/if_id_stage_id_field_decode.sv
// Combinational MIPS field splitter plus immediate-extension select.
// Reusable by any stage that holds a raw instruction word.
module id_field_decode
  import if_id_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic        extop_o,
  output logic [25:0] jidx_o
);

  assign opcode_o = instr_i[OPCODE_MSB:OPCODE_LSB];
  assign rs_o     = instr_i[RS_MSB:RS_LSB];
  assign rt_o     = instr_i[RT_MSB:RT_LSB];
  assign rd_o     = instr_i[RD_MSB:RD_LSB];
  assign shamt_o  = instr_i[SHAMT_MSB:SHAMT_LSB];
  assign funct_o  = instr_i[FUNCT_MSB:FUNCT_LSB];
  assign imm16_o  = instr_i[IMM_MSB:IMM_LSB];
  assign jidx_o   = instr_i[JIDX_MSB:JIDX_LSB];
  assign extop_o  = ext_op(instr_i[OPCODE_MSB:OPCODE_LSB]);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake, stall and flush.
// Optional IF_ID_STALL_CNT_EN adds a free-running stall cycle counter.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        load;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  // Flush wins over a simultaneous load; PCs survive a flush on purpose.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d    = 1'b1;
      pc_d       = bus.in_pc;
      pc_plus4_d = bus.in_pc + 32'd4;
      instr_d    = bus.in_instr;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_pc_plus4 = pc_plus4_q;

  id_field_decode u_field_decode (
    .instr_i  (instr_q),
    .opcode_o (bus.out_opcode),
    .rs_o     (bus.out_rs),
    .rt_o     (bus.out_rt),
    .rd_o     (bus.out_rd),
    .shamt_o  (bus.out_shamt),
    .funct_o  (bus.out_funct),
    .imm16_o  (bus.out_imm16),
    .extop_o  (bus.out_extop),
    .jidx_o   (bus.out_jidx)
  );

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !bus.out_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed plan steps followed by random
// traffic, all checked against a transaction-level model of the held word.
module tb_if_id_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_id_stage_if bus ();

  if_id_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          mValid;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mStall;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-extension applies only to andi/ori/xori/lui.
  function automatic logic expExtop(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    case (op)
      6'h0C, 6'h0D, 6'h0E, 6'h0F: return 1'b0;
      default:                    return 1'b1;
    endcase
  endfunction

  task automatic modelReset();
    mValid = 1'b0;
    mPc    = RESET_PC;
    mInstr = NOP;
    mStall = 32'd0;
  endtask

  task automatic checkState(input string tag);
    logic [31:0] pc4;
    pc4 = mPc + 32'd4;
    checkOutput({tag, ".valid"},  32'(bus.out_valid),    32'(mValid));
    checkOutput({tag, ".pc"},     bus.out_pc,            mPc);
    checkOutput({tag, ".pc4"},    bus.out_pc_plus4,      pc4);
    checkOutput({tag, ".opcode"}, 32'(bus.out_opcode),   32'(mInstr[31:26]));
    checkOutput({tag, ".rs"},     32'(bus.out_rs),       32'(mInstr[25:21]));
    checkOutput({tag, ".rt"},     32'(bus.out_rt),       32'(mInstr[20:16]));
    checkOutput({tag, ".rd"},     32'(bus.out_rd),       32'(mInstr[15:11]));
    checkOutput({tag, ".shamt"},  32'(bus.out_shamt),    32'(mInstr[10:6]));
    checkOutput({tag, ".funct"},  32'(bus.out_funct),    32'(mInstr[5:0]));
    checkOutput({tag, ".imm16"},  32'(bus.out_imm16),    32'(mInstr[15:0]));
    checkOutput({tag, ".jidx"},   32'(bus.out_jidx),     32'(mInstr[25:0]));
    checkOutput({tag, ".extop"},  32'(bus.out_extop),    32'(expExtop(mInstr)));
`ifdef IF_ID_STALL_CNT_EN
    checkOutput({tag, ".stall_cnt"}, bus.stall_cnt, mStall);
`endif
  endtask

  // Called at a falling edge: drive inputs, check in_ready, advance model, check after the rising edge.
  task automatic applyStimulus(input bit fl, input bit v, input logic [31:0] pc,
                               input logic [31:0] instr, input bit rdy, input string tag);
    bus.flush     = fl;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.out_ready = rdy;
    #1;
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!mValid || rdy));
    if (mValid && !rdy) mStall = mStall + 32'd1;
    if (fl) begin
      mValid = 1'b0;
      mInstr = NOP;
    end else if (v && (!mValid || rdy)) begin
      mValid = 1'b1;
      mPc    = pc;
      mInstr = instr;
    end else if (mValid && rdy) begin
      mValid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checkState(tag);
  endtask

  initial begin
    logic [31:0] stream [4];
    logic [31:0] prevOut;
    stream[0] = 32'h8C43_0010;
    stream[1] = 32'hAC43_0014;
    stream[2] = 32'h0043_2020;
    stream[3] = 32'h3C01_1234;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'd0;
    bus.in_instr  = 32'd0;
    bus.out_ready = 1'b0;
    modelReset();

    repeat (2) @(negedge clk);
    checkState("reset");
    rst = 1'b0;
    #1;
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset.pc_lit", bus.out_pc, 32'hBFC0_0000);
    checkOutput("reset.pc4_lit", bus.out_pc_plus4, 32'hBFC0_0004);
    checkOutput("reset.extop_lit", 32'(bus.out_extop), 32'd1);
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 32'h0040_0000, 32'h3422_8000, 1'b1, "ori");
    checkOutput("ori.opcode_lit", 32'(bus.out_opcode), 32'h0D);
    checkOutput("ori.imm_lit", 32'(bus.out_imm16), 32'h8000);
    checkOutput("ori.extop_lit", 32'(bus.out_extop), 32'd0);
    checkOutput("ori.pc4_lit", bus.out_pc_plus4, 32'h0040_0004);

    applyStimulus(1'b0, 1'b1, 32'h0040_0004, 32'h2422_FFFF, 1'b1, "addiu");
    checkOutput("addiu.extop_lit", 32'(bus.out_extop), 32'd1);
    checkOutput("addiu.imm_lit", 32'(bus.out_imm16), 32'hFFFF);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0040_0008, 32'h3C05_ABCD, 1'b0, "stall");
      checkOutput("stall.imm_lit", 32'(bus.out_imm16), 32'hFFFF);
    end
`ifdef IF_ID_STALL_CNT_EN
    checkOutput("stall.cnt_lit", bus.stall_cnt, 32'd3);
`endif

    applyStimulus(1'b1, 1'b1, 32'h0040_0008, 32'h2001_0005, 1'b0, "flush");
    checkOutput("flush.valid_lit", 32'(bus.out_valid), 32'd0);
    checkOutput("flush.opcode_lit", 32'(bus.out_opcode), 32'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_1000 + 32'(i * 4), stream[i], 1'b1, "stream");
      prevOut = {bus.out_opcode, bus.out_jidx};
      checkOutput("stream.word", prevOut, stream[i]);
    end

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1000_FFFF, 1'b1, "wrap");
    checkOutput("wrap.pc4_lit", bus.out_pc_plus4, 32'h0000_0000);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "drain");

    applyStimulus(1'b0, 1'b1, 32'h0000_2000, 32'h3042_00FF, 1'b0, "preReset");
    applyStimulus(1'b0, 1'b1, 32'h0000_2004, 32'h2042_0001, 1'b0, "preReset.stall");
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("midReset.valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midReset.pc", bus.out_pc, RESET_PC);
    checkOutput("midReset.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkState("midReset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0), $urandom,
                    $urandom, 1'($urandom_range(0, 2) != 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
